// File: rtl/bus_requester.sv
// bus_requester: core-to-bus requester FSM; CPU_* handshake in, REQ/ACCESS to arbiter, BUS_* strobe with ack and timeout
module bus_requester #(
  parameter int AddrWidth     = 16,
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 CPU_VALID,
  output logic                 CPU_READY,
  input  logic                 CPU_WE,
  input  logic [AddrWidth-1:0] CPU_ADDR,
  input  logic [DataWidth-1:0] CPU_WDATA,
  output logic [DataWidth-1:0] CPU_RDATA,
  output logic                 CPU_DONE,
  output logic                 CPU_ERR,
  output logic                 REQ,
  input  logic                 ACCESS,
  output logic                 BUS_EN,
  output logic                 BUS_WE,
  output logic [AddrWidth-1:0] BUS_ADDR,
  output logic [DataWidth-1:0] BUS_WDATA,
  input  logic [DataWidth-1:0] BUS_RDATA,
  input  logic                 BUS_ACK
);
  typedef enum logic [1:0] {IDLE, REQUEST, TRANSFER, RELEASE} state_e;
  state_e               state_q, state_d;
  logic                 we_q, we_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [DataWidth-1:0] wdata_q, wdata_d;
  logic [DataWidth-1:0] rdata_q, rdata_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic                 timeout;
  assign timeout = cnt_q == 8'(TimeoutCycles - 1);
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (CPU_VALID) begin
        state_d = REQUEST;
        we_d    = CPU_WE;
        addr_d  = CPU_ADDR;
        wdata_d = CPU_WDATA;
      end
      REQUEST: if (ACCESS) begin
        state_d = TRANSFER;
        cnt_d   = '0;
      end
      TRANSFER: if (BUS_ACK) begin
        state_d = RELEASE;
        rdata_d = we_q ? rdata_q : BUS_RDATA;
      end else begin
        cnt_d   = cnt_q + 8'd1;
        state_d = timeout ? RELEASE : ACCESS ? TRANSFER : REQUEST;
        err_d   = timeout;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end
  assign CPU_READY = state_q == IDLE;
  assign REQ       = state_q == REQUEST || state_q == TRANSFER;
  assign BUS_EN    = state_q == TRANSFER;
  assign CPU_DONE  = state_q == RELEASE;
  assign CPU_ERR   = err_q;
  assign CPU_RDATA = rdata_q;
  assign BUS_WE    = BUS_EN & we_q;
  assign BUS_ADDR  = BUS_EN ? addr_q : '0;
  assign BUS_WDATA = BUS_EN ? wdata_q : '0;
endmodule

// File: tb/tb_bus_requester.sv
// tb_bus_requester: randomized transaction-level check of bus_requester plus a 4-requester round-robin run
module tb_bus_requester;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int T  = 16;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, multi, cpu_valid, cpu_we, access, bus_ack;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, bus_rdata;
  logic v_valid [4], v_we [4], v_access [4], v_ack [4];
  logic v_ready [4], v_done [4], v_err [4], v_req [4], v_en [4], v_bwe [4];
  logic [AW-1:0] v_addr [4], v_baddr [4];
  logic [DW-1:0] v_wdata [4], v_rdata [4], v_bwdata [4];
  logic [3:0] grant, req_vec, arb_nxt;
  logic [1:0] last, arb_last;
  logic [DW-1:0] model_rdata;
  int checks = 0, errors = 0;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      v_valid[i]  = multi ? 1'b1 : (i == 0) & cpu_valid;
      v_we[i]     = multi ? 1'b0 : cpu_we;
      v_addr[i]   = multi ? AW'(32'h100 + i) : cpu_addr;
      v_wdata[i]  = cpu_wdata;
      v_access[i] = multi ? grant[i] : (i == 0) & access;
      v_ack[i]    = multi ? v_en[i] : (i == 0) & bus_ack;
      req_vec[i]  = v_req[i];
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_dut
    bus_requester #(.AddrWidth(AW), .DataWidth(DW), .TimeoutCycles(T)) dut (
      .CLK(clk), .RST(rst), .CPU_VALID(v_valid[g]), .CPU_READY(v_ready[g]),
      .CPU_WE(v_we[g]), .CPU_ADDR(v_addr[g]), .CPU_WDATA(v_wdata[g]),
      .CPU_RDATA(v_rdata[g]), .CPU_DONE(v_done[g]), .CPU_ERR(v_err[g]),
      .REQ(v_req[g]), .ACCESS(v_access[g]), .BUS_EN(v_en[g]), .BUS_WE(v_bwe[g]),
      .BUS_ADDR(v_baddr[g]), .BUS_WDATA(v_bwdata[g]), .BUS_RDATA(bus_rdata),
      .BUS_ACK(v_ack[g]));
  end

  always_comb begin
    arb_nxt  = '0;
    arb_last = last;
    for (int k = 4; k >= 1; k--) begin
      if (req_vec[2'(last + k)]) begin
        arb_nxt  = 4'b1 << 2'(last + k);
        arb_last = 2'(last + k);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      grant <= '0;
      last  <= 2'd3;
    end else if ((grant & req_vec) == 4'd0) begin
      grant <= arb_nxt;
      last  <= arb_last;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_ready"}, v_ready[0], 1);
    chk({tag, "_req"}, v_req[0], 0);
    chk({tag, "_en"}, v_en[0], 0);
    chk({tag, "_done"}, v_done[0], 0);
    chk({tag, "_err"}, v_err[0], 0);
    chk({tag, "_bus"}, {v_bwe[0], v_baddr[0], v_bwdata[0]}, 0);
  endtask

  task automatic run_txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                         input logic [DW-1:0] rd, input int gw, input int drop_at,
                         input int ack_at, input logic collide);
    int en_cyc, rq_cyc, tot_en, tot_rq, exp_en, exp_rq;
    logic dropped, done, fin;
    logic [DW-1:0] exp_rd;
    exp_en = (drop_at >= 0 ? drop_at + 1 : 0) + (ack_at < T ? ack_at + 1 : T);
    exp_rq = gw + 1 + (drop_at >= 0 ? 1 : 0);
    exp_rd = (ack_at < T && !we) ? rd : model_rdata;
    en_cyc = 0; rq_cyc = 0; tot_en = 0; tot_rq = 0; dropped = 0; done = 0;
    @(negedge clk);
    chk("ready_before", v_ready[0], 1);
    cpu_valid = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    access = 0; bus_ack = 0;
    for (int cyc = 1; cyc <= 300 && !done; cyc++) begin
      @(negedge clk);
      cpu_valid = 1'($urandom_range(0, 1)); cpu_we = 1'($urandom);
      cpu_addr = AW'($urandom); cpu_wdata = $urandom;
      bus_rdata = $urandom; access = 0; bus_ack = 0;
      if (v_done[0]) begin
        done = 1;
        cpu_valid = 0;
        chk("done_cycle", cyc, exp_rq + exp_en + 1);
        chk("err", v_err[0], ack_at >= T);
        chk("rdata", v_rdata[0], exp_rd);
        chk("req_release", v_req[0], 0);
        chk("en_release", v_en[0], 0);
        chk("en_count", tot_en, exp_en);
        chk("req_wait_count", tot_rq, exp_rq);
      end else if (v_en[0]) begin
        tot_en++;
        chk("bus_addr", v_baddr[0], addr);
        chk("bus_we", v_bwe[0], we);
        chk("bus_wdata", v_bwdata[0], wd);
        chk("req_xfer", v_req[0], 1);
        chk("busy_ready", v_ready[0], 0);
        chk("busy_err", v_err[0], 0);
        fin = drop_at < 0 || dropped;
        if (fin && en_cyc == ack_at) begin
          bus_ack = 1; bus_rdata = rd; access = !collide;
        end else if (!fin && en_cyc == drop_at) begin
          dropped = 1;
        end else access = 1;
        en_cyc++;
      end else begin
        tot_rq++;
        rq_cyc++;
        en_cyc = 0;
        chk("req_wait", v_req[0], 1);
        chk("wait_bus", {v_bwe[0], v_baddr[0], v_bwdata[0]}, 0);
        chk("busy_ready", v_ready[0], 0);
        chk("busy_err", v_err[0], 0);
        access = dropped || rq_cyc > gw;
      end
    end
    if (!done) chk("done_bound", 0, 1);
    @(negedge clk);
    idle_chk("after");
    model_rdata = exp_rd;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ngr, exp_i, hot;
    logic prev_en [4];
    rst = 1; multi = 0; cpu_valid = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    access = 0; bus_ack = 0; bus_rdata = '0; model_rdata = '0;
    repeat (2) @(negedge clk);
    idle_chk("reset");
    chk("reset_rdata", v_rdata[0], 0);
    rst = 0;
    run_txn(0, 16'h0040, 32'h0, 32'hDEADBEEF, 1, -1, 1, 0);
    run_txn(1, 16'h0123, 32'h12345678, 32'hCAFEF00D, 0, -1, 2, 0);
    run_txn(0, 16'h0200, 32'h0, 32'h11111111, 0, -1, T, 0);
    run_txn(0, 16'h0300, 32'h0, 32'h22222222, 0, 1, 3, 0);
    run_txn(0, 16'h0400, 32'h0, 32'h33333333, 0, -1, 2, 1);
    run_txn(0, 16'h0500, 32'h0, 32'h44444444, 2, -1, T - 1, 0);
    for (int n = 0; n < 40; n++)
      run_txn(1'($urandom), AW'($urandom), $urandom, $urandom, $urandom_range(0, 3),
              $urandom_range(0, 3) == 0 ? $urandom_range(0, T - 2) : -1,
              $urandom_range(0, 4) == 0 ? T : $urandom_range(0, T - 1),
              1'($urandom_range(0, 3) == 0));
    run_txn(0, 16'h0600, 32'h0, 32'h5A5A5A5A, 0, -1, 0, 0);
    @(negedge clk);
    cpu_valid = 1; cpu_we = 1; cpu_addr = 16'h0055; cpu_wdata = 32'h77; access = 1;
    @(negedge clk);
    cpu_valid = 0;
    @(negedge clk);
    chk("en_before_rst", v_en[0], 1);
    rst = 1;
    @(negedge clk);
    rst = 0; access = 0;
    idle_chk("mid_rst");
    chk("mid_rst_rdata", v_rdata[0], 0);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("no_done_after_rst", v_done[0], 0);
    end
    rst = 1;
    @(negedge clk);
    rst = 0; multi = 1; ngr = 0; exp_i = 0;
    for (int i = 0; i < 4; i++) prev_en[i] = 0;
    for (int cyc = 0; cyc < 600 && ngr < 12; cyc++) begin
      @(negedge clk);
      hot = 0;
      for (int i = 0; i < 4; i++) begin
        hot += int'(v_en[i]);
        if (v_en[i] && !prev_en[i]) begin
          chk("rr_order", i, exp_i);
          chk("rr_addr", v_baddr[i], 32'h100 + i);
          exp_i = (i + 1) % 4;
          ngr++;
        end
        prev_en[i] = v_en[i];
      end
      chk("one_bus_en", hot <= 1, 1);
    end
    chk("rr_grants", ngr, 12);
    multi = 0;
    rst = 1;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
